// File: rtl/fifo_pop_stage_pkg.sv
// Shared constants for the FIFO pop stage: default geometry, the depth helper and the
// reset values that the stage and the downstream demux checker both rely on.
package fifo_pop_stage_pkg;

  localparam int DEFAULT_DATA_SIZE = 4;
  localparam int DEFAULT_ADDR_SIZE = 2;

  localparam int   RST_DATA_WORD  = 0;
  localparam logic RST_VALID_OUT  = 1'b0;
  localparam logic RST_FIFO_ERROR = 1'b0;

  function automatic int fifo_depth(input int addr_size);
    return 1 << addr_size;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Dual-port register array: synchronous write port and a registered read port with read enable.
// The read register resets to the shared data reset value; the storage cells are never reset.
module fifo_mem
  import fifo_pop_stage_pkg::*;
#(
  parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
  parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 wr_en,
  input  logic [ADDR_SIZE-1:0] wr_addr,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  output logic [DATA_SIZE-1:0] rd_data
);

  localparam int DEPTH = fifo_depth(ADDR_SIZE);

  logic [DATA_SIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // A same-edge write to rd_addr is not visible here, so a full push+pop reads the old word.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)   rd_data <= DATA_SIZE'(RST_DATA_WORD);
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fifo_pop_stage.sv
// Synchronous FIFO feeding the demux stage, with occupancy flags and an error flag.
// Define FIFO_ERR_STICKY_EN to make fifo_error hold until reset instead of pulsing.
module fifo_pop_stage
  import fifo_pop_stage_pkg::*;
#(
  parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
  parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 push,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic                 pop,
  input  logic [ADDR_SIZE:0]   umbral_alto,
  input  logic [ADDR_SIZE:0]   umbral_bajo,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 valid_out,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 fifo_error
);

  localparam logic [ADDR_SIZE:0] DEPTH = (ADDR_SIZE + 1)'(fifo_depth(ADDR_SIZE));

  logic [ADDR_SIZE-1:0] wr_ptr;
  logic [ADDR_SIZE-1:0] rd_ptr;
  logic [ADDR_SIZE:0]   count;
  logic                 push_ok;
  logic                 pop_ok;
  logic                 error_event;

  assign full         = (count == DEPTH);
  assign empty        = (count == '0);
  assign almost_full  = (count >= umbral_alto);
  assign almost_empty = (count <= umbral_bajo);

  // A pop frees a slot in the same cycle, so a full FIFO may still take a push alongside it.
  assign push_ok     = push && (!full || pop);
  assign pop_ok      = pop && !empty;
  assign error_event = (push && full && !pop) || (pop && empty);

  fifo_mem #(
    .DATA_SIZE(DATA_SIZE),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_mem (
    .clk    (clk),
    .reset_L(reset_L),
    .wr_en  (push_ok),
    .wr_addr(wr_ptr),
    .wr_data(data_in),
    .rd_en  (pop_ok),
    .rd_addr(rd_ptr),
    .rd_data(data_out)
  );

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      valid_out <= RST_VALID_OUT;
    end else begin
      valid_out <= pop_ok;
      if (push_ok) wr_ptr <= wr_ptr + ADDR_SIZE'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + ADDR_SIZE'(1);
      if (push_ok && !pop_ok)      count <= count + (ADDR_SIZE + 1)'(1);
      else if (pop_ok && !push_ok) count <= count - (ADDR_SIZE + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      fifo_error <= RST_FIFO_ERROR;
    end else begin
`ifdef FIFO_ERR_STICKY_EN
      if (error_event) fifo_error <= 1'b1;
`else
      fifo_error <= error_event;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_pop_stage.sv
// Directed bench for fifo_pop_stage: hand-computed flag, data and error expectations
// for the default 4x4 geometry; error expectations adapt to FIFO_ERR_STICKY_EN.
module tb_fifo_pop_stage;

`ifdef FIFO_ERR_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_L;
  logic       push;
  logic [3:0] data_in;
  logic       pop;
  logic [2:0] umbral_alto;
  logic [2:0] umbral_bajo;
  logic [3:0] data_out;
  logic       valid_out;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       fifo_error;

  int vectors    = 0;
  int miscompares = 0;
  bit sawError   = 1'b0;

  fifo_pop_stage #(.DATA_SIZE(4), .ADDR_SIZE(2)) dut (
    .clk         (clk),
    .reset_L     (reset_L),
    .push        (push),
    .data_in     (data_in),
    .pop         (pop),
    .umbral_alto (umbral_alto),
    .umbral_bajo (umbral_bajo),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .fifo_error  (fifo_error)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then settle just past the next rising edge.
  task automatic applyStimulus(input logic p, input logic [3:0] d, input logic q);
    @(negedge clk);
    push = p; data_in = d; pop = q;
    @(posedge clk);
    #1;
  endtask

  task automatic checkFlags(input string tag, input logic e, input logic ae, input logic f, input logic af);
    checkOutput({tag, ".empty"}, {7'd0, empty}, {7'd0, e});
    checkOutput({tag, ".almost_empty"}, {7'd0, almost_empty}, {7'd0, ae});
    checkOutput({tag, ".full"}, {7'd0, full}, {7'd0, f});
    checkOutput({tag, ".almost_full"}, {7'd0, almost_full}, {7'd0, af});
  endtask

  task automatic checkRead(input string tag, input logic v, input logic [3:0] d);
    checkOutput({tag, ".valid_out"}, {7'd0, valid_out}, {7'd0, v});
    checkOutput({tag, ".data_out"}, {4'd0, data_out}, {4'd0, d});
  endtask

  // Error flag model: pulse on the cycle after an event, or latched until reset when sticky.
  task automatic checkErr(input string tag, input bit event_seen);
    logic expected;
    if (event_seen) sawError = 1'b1;
    expected = event_seen | (STICKY & sawError);
    checkOutput({tag, ".fifo_error"}, {7'd0, fifo_error}, {7'd0, expected});
  endtask

  initial begin
    reset_L = 1'b0; push = 1'b0; pop = 1'b0; data_in = 4'h0;
    umbral_alto = 3'd3; umbral_bajo = 3'd1;
    #12;
    checkFlags("rst", 1, 1, 0, 0);
    checkRead("rst", 0, 4'h0);
    checkErr("rst", 0);
    umbral_alto = 3'd0; #1;
    checkOutput("rst_alto0.almost_full", {7'd0, almost_full}, 8'd1);
    umbral_alto = 3'd3; #1;
    @(negedge clk) reset_L = 1'b1;

    applyStimulus(0, 4'h0, 0);
    checkFlags("idle", 1, 1, 0, 0);
    checkRead("idle", 0, 4'h0);

    // Fill F,E,D,C then drain in order.
    applyStimulus(1, 4'hF, 0); checkFlags("push1", 0, 1, 0, 0);
    applyStimulus(1, 4'hE, 0); checkFlags("push2", 0, 0, 0, 0);
    applyStimulus(1, 4'hD, 0); checkFlags("push3", 0, 0, 0, 1);
    applyStimulus(1, 4'hC, 0); checkFlags("push4", 0, 0, 1, 1);
    umbral_alto = 3'd5; #1;
    checkOutput("alto5.almost_full", {7'd0, almost_full}, 8'd0);
    umbral_alto = 3'd4; #1;
    checkOutput("alto4.almost_full", {7'd0, almost_full}, 8'd1);
    umbral_alto = 3'd3;
    applyStimulus(0, 4'h0, 1); checkRead("pop1", 1, 4'hF); checkFlags("pop1", 0, 0, 0, 1);
    applyStimulus(0, 4'h0, 1); checkRead("pop2", 1, 4'hE); checkFlags("pop2", 0, 0, 0, 0);
    applyStimulus(0, 4'h0, 1); checkRead("pop3", 1, 4'hD); checkFlags("pop3", 0, 1, 0, 0);
    applyStimulus(0, 4'h0, 1); checkRead("pop4", 1, 4'hC); checkFlags("pop4", 1, 1, 0, 0);
    applyStimulus(0, 4'h0, 0); checkRead("hold", 0, 4'hC); checkErr("hold", 0);

    // Overflow: push while full without pop is rejected.
    applyStimulus(1, 4'h1, 0);
    applyStimulus(1, 4'h2, 0);
    applyStimulus(1, 4'h3, 0);
    applyStimulus(1, 4'h4, 0); checkFlags("ovf_fill", 0, 0, 1, 1); checkErr("ovf_fill", 0);
    applyStimulus(1, 4'h5, 0); checkErr("ovf", 1); checkFlags("ovf", 0, 0, 1, 1);
    applyStimulus(0, 4'h0, 0); checkErr("ovf_after", 0);
    applyStimulus(0, 4'h0, 1); checkRead("ovf_pop1", 1, 4'h1);
    applyStimulus(0, 4'h0, 1); checkRead("ovf_pop2", 1, 4'h2);
    applyStimulus(0, 4'h0, 1); checkRead("ovf_pop3", 1, 4'h3);
    applyStimulus(0, 4'h0, 1); checkRead("ovf_pop4", 1, 4'h4); checkFlags("ovf_drained", 1, 1, 0, 0);

    // Underflow: pop alone on empty.
    applyStimulus(0, 4'h0, 1); checkErr("unf", 1); checkRead("unf", 0, 4'h4);
    applyStimulus(0, 4'h0, 0); checkErr("unf_after", 0);
    umbral_bajo = 3'd0; #1;
    checkOutput("bajo0_empty.almost_empty", {7'd0, almost_empty}, 8'd1);

    // Push+pop on empty: push stored, pop rejected, no read-through.
    applyStimulus(1, 4'h3, 1); checkErr("pp_empty", 1); checkRead("pp_empty", 0, 4'h4);
    checkFlags("pp_empty", 0, 0, 0, 0);
    umbral_bajo = 3'd1;
    applyStimulus(0, 4'h0, 1); checkRead("pp_pop", 1, 4'h3); checkFlags("pp_pop", 1, 1, 0, 0);
    checkErr("pp_pop", 0);

    // Full with simultaneous push+pop across pointer wrap.
    applyStimulus(1, 4'h6, 0);
    applyStimulus(1, 4'h7, 0);
    applyStimulus(1, 4'h8, 0);
    applyStimulus(1, 4'h9, 0);
    for (int i = 0; i < 6; i++) begin
      logic [3:0] din;
      logic [3:0] dexp;
      din  = 4'hA + 4'(i);
      dexp = 4'h6 + 4'(i);
      applyStimulus(1, din, 1);
      checkRead($sformatf("wrap%0d", i), 1, dexp);
      checkOutput($sformatf("wrap%0d.full", i), {7'd0, full}, 8'd1);
      checkErr($sformatf("wrap%0d", i), 0);
    end
    applyStimulus(0, 4'h0, 1); checkRead("wrap_d1", 1, 4'hC);
    applyStimulus(0, 4'h0, 1); checkRead("wrap_d2", 1, 4'hD);
    applyStimulus(0, 4'h0, 1); checkRead("wrap_d3", 1, 4'hE);
    applyStimulus(0, 4'h0, 1); checkRead("wrap_d4", 1, 4'hF); checkFlags("wrap_drained", 1, 1, 0, 0);

    // Mid-stream asynchronous reset with two words stored.
    applyStimulus(1, 4'h1, 0);
    applyStimulus(1, 4'h2, 0); checkFlags("pre_rst", 0, 0, 0, 0);
    @(negedge clk);
    push = 1'b0; pop = 1'b0;
    #2 reset_L = 1'b0;
    #1;
    sawError = 1'b0;
    checkFlags("async_rst", 1, 1, 0, 0);
    checkRead("async_rst", 0, 4'h0);
    checkErr("async_rst", 0);
    @(negedge clk) reset_L = 1'b1;
    applyStimulus(1, 4'h7, 0);
    applyStimulus(1, 4'h8, 0);
    applyStimulus(0, 4'h0, 1); checkRead("post_rst1", 1, 4'h7);
    applyStimulus(0, 4'h0, 1); checkRead("post_rst2", 1, 4'h8); checkFlags("post_rst", 1, 1, 0, 0);

    // Repeat overflow to check pulse vs sticky behaviour over several idle cycles.
    applyStimulus(1, 4'h1, 0);
    applyStimulus(1, 4'h2, 0);
    applyStimulus(1, 4'h3, 0);
    applyStimulus(1, 4'h4, 0);
    applyStimulus(1, 4'h5, 0); checkErr("ovf2", 1);
    applyStimulus(0, 4'h0, 0); checkErr("ovf2_idle1", 0);
    applyStimulus(0, 4'h0, 0); checkErr("ovf2_idle2", 0);
    applyStimulus(0, 4'h0, 1); checkRead("ovf2_pop1", 1, 4'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_pop_stage.md
# fifo_pop_stage

Parameterised synchronous FIFO that buffers words from the upstream source and feeds the demux stage. The demux consumes `data_out` and `valid_out` on the cycle after a pop. Occupancy flags (`full`, `empty`, programmable `almost_full` and `almost_empty`) drive upstream flow control, and an error flag reports overflow and underflow attempts.

## Interface
- `DATA_SIZE`, default 4: width of a data word.
- `ADDR_SIZE`, default 2: pointer width; depth = 2^ADDR_SIZE (4 words).
- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset_L`  in  1: reset, asynchronous, active-low.
- `push`  in  1: write request; `data_in` is captured when accepted.
- `data_in`  in  DATA_SIZE: write data.
- `pop`  in  1: read request.
- `umbral_alto`  in  ADDR_SIZE+1: almost-full threshold.
- `umbral_bajo`  in  ADDR_SIZE+1: almost-empty threshold.
- `data_out`  out  DATA_SIZE: registered read data.
- `valid_out`  out  1: `data_out` holds a popped word this cycle.
- `full`  out  1: count == depth.
- `empty`  out  1: count == 0.
- `almost_full`  out  1: count >= `umbral_alto`.
- `almost_empty`  out  1: count <= `umbral_bajo`.
- `fifo_error`  out  1: overflow or underflow attempt.

## Operation
- State:
  - write pointer `wr_ptr` and read pointer `rd_ptr`, each ADDR_SIZE bits, wrapping modulo depth;
  - occupancy `count`, ADDR_SIZE+1 bits, range 0..depth;
  - memory array of depth × DATA_SIZE.
- Push accept rule: `push` && (!`full` || `pop`). On accept, write `data_in` at `wr_ptr` and increment `wr_ptr`.
- Pop accept rule: `pop` && !`empty`. On accept, register mem[`rd_ptr`] into `data_out`, set `valid_out`=1, and increment `rd_ptr`.
- No accepted pop: `valid_out`=0 and `data_out` holds its last value.
- Count update: +1 for an accepted push only, −1 for an accepted pop only, unchanged for both or neither.
- Push and pop together while full: both are accepted. The read uses the old slot; the write lands in the slot freed that cycle; count stays at depth.
- Push and pop together while empty: the push is accepted, the pop is rejected, `fifo_error` is raised, and `valid_out`=0. There is no read-through.
- Error sources: push while full without a pop, or pop while empty.
- Flags are combinational decodes of the registered `count` and the threshold inputs. Thresholds may change at any time, and the flags follow them in the same cycle.
- A threshold above depth makes `almost_full` unreachable. `umbral_bajo`=0 makes `almost_empty` equal to `empty`.

## Timing
- Reset values, applied immediately on `reset_L` low:
  - pointers and count 0;
  - `data_out`=0, `valid_out`=0, `fifo_error`=0;
  - `full`=0, `empty`=1;
  - `almost_empty`=1 (count 0 <= any `umbral_bajo`);
  - `almost_full`=1 only if `umbral_alto`=0.
- Reset mid-operation: stored contents are logically discarded, and the first pop after release returns the first word pushed after release. Memory cells need no reset.
- Write-to-flag latency: count and flags update 1 cycle after the push edge.
- Pop latency: `data_out`/`valid_out` are valid 1 cycle after the edge that samples `pop`.
- Minimum push-to-pop-data latency is 2 cycles: push at edge N, pop sampled at edge N+1, data out after edge N+1.
- Sustained throughput is one push and one pop per cycle.

## Configuration
- Macro: `FIFO_ERR_STICKY_EN`.
- Defined: `fifo_error` sets on the first error event and holds 1 until `reset_L` is asserted.
- Undefined: `fifo_error` is a registered one-cycle pulse, high in the cycle after each error event and cleared when there is no event.
- The rejected operation never changes pointers or count in either build.

## Structure
- Shared include file holds:
  - the default `DATA_SIZE`/`ADDR_SIZE` constants;
  - the depth computation (1 << ADDR_SIZE);
  - reset-value constants used by the stage and by the demux checker.
- Sub-module `fifo_mem`: dual-port register array with a synchronous write port and a synchronous registered read port with read enable. It is instantiated once.
- Pointer, count, flag and error logic live in `fifo_pop_stage`.

## Test plan
- Reset then idle, with `umbral_alto`=3 and `umbral_bajo`=1:
  - `empty`=1, `almost_empty`=1, `full`=0, `almost_full`=0;
  - `valid_out`=0, `data_out`=0, `fifo_error`=0.
- Push 0xF, 0xE, 0xD, 0xC on consecutive cycles:
  - `almost_full` rises after the 3rd push, `full` after the 4th;
  - then pop ×4 returns F, E, D, C, one per cycle with `valid_out`=1;
  - `empty` returns to 1.
- Fill to full, then push 0x5 without pop: `fifo_error` asserts; count stays 4; subsequent pops return the original 4 words and never 0x5.
- On an empty FIFO, pop alone: `fifo_error` asserts and `valid_out`=0.
- On an empty FIFO, push 0x3 with a simultaneous pop: 0x3 is stored, count=1, and the next pop returns 0x3.
- While full, simultaneous push 0xA and pop for 6 cycles: count stays 4, output order is preserved across pointer wrap-around, and `fifo_error` stays 0.
- Assert `reset_L` mid-stream with 2 words stored: all outputs return to their reset values asynchronously. After release, push 0x7, 0x8 then pop ×2 returns 7, 8.
- Repeat the overflow scenario in both builds: with `FIFO_ERR_STICKY_EN` the error stays high; without it the error is a single-cycle pulse.
